// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one multi-cycle FP multiplier between two requesters.
// One operation in flight; results return with a valid pulse, or TO_RESULT after a timeout.
`default_nettype none

module fp_mul_arbiter #(
    parameter int          TIMEOUT_CYCLES = 32,
    parameter logic [31:0] TO_RESULT      = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic [31:0] a_op1,
    input  logic [31:0] a_op2,
    output logic        a_ack,
    output logic        a_valid,
    input  logic        b_req,
    input  logic [31:0] b_op1,
    input  logic [31:0] b_op2,
    output logic        b_ack,
    output logic        b_valid,
    output logic [31:0] res_out,
    output logic        timeout,
    output logic        busy,
    output logic        mul_ready,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic [31:0] mul_res,
    input  logic        mul_done
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_b_q;
    logic             mul_ready_q;
    logic             a_valid_q;
    logic             b_valid_q;
    logic             timeout_q;
    logic [31:0]      res_q;
    logic [31:0]      op1_q;
    logic [31:0]      op2_q;

    logic             grant_a_d;
    logic             grant_b_d;

    // Under contention the requester that was not granted last wins.
    always_comb begin
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        if (state_q == S_IDLE) begin
            grant_a_d = a_req & (~b_req | last_b_q);
            grant_b_d = b_req & ~grant_a_d;
        end
    end

    // Ack is asserted in the IDLE cycle whose closing edge captures the operands.
    assign a_ack = grant_a_d & ~rst;
    assign b_ack = grant_b_d & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            mul_ready_q <= 1'b0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            timeout_q   <= 1'b0;
            res_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            mul_ready_q <= 1'b0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            timeout_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_a_d || grant_b_d) begin
                        op1_q       <= grant_a_d ? a_op1 : b_op1;
                        op2_q       <= grant_a_d ? a_op2 : b_op2;
                        last_b_q    <= grant_b_d;
                        mul_ready_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the last allowed cycle still counts as success.
                    if (mul_done) begin
                        res_q     <= mul_res;
                        a_valid_q <= ~last_b_q;
                        b_valid_q <= last_b_q;
                        state_q   <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        res_q     <= TO_RESULT;
                        a_valid_q <= ~last_b_q;
                        b_valid_q <= last_b_q;
                        timeout_q <= 1'b1;
                        state_q   <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mul_ready = mul_ready_q;
    assign mul_op1   = op1_q;
    assign mul_op2   = op2_q;
    assign a_valid   = a_valid_q;
    assign b_valid   = b_valid_q;
    assign timeout   = timeout_q;
    assign res_out   = res_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed and randomized checks of fp_mul_arbiter against a timing-level model,
// with a latency-programmable multiplier stub standing in for the real multiplier.
`default_nettype none

module tb_fp_mul_arbiter;

    localparam int          TO    = 32;
    localparam logic [31:0] TOR   = 32'h7FC00000;
    localparam int          NEVER = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [31:0] a_op1 = '0, a_op2 = '0, b_op1 = '0, b_op2 = '0;
    logic [31:0] mul_res = '0;
    logic        mul_done = 1'b0;
    logic        a_ack, a_valid, b_ack, b_valid, timeout, busy, mul_ready;
    logic [31:0] res_out, mul_op1, mul_op2;

    fp_mul_arbiter #(.TIMEOUT_CYCLES(TO), .TO_RESULT(TOR)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_op1(a_op1), .a_op2(a_op2), .a_ack(a_ack), .a_valid(a_valid),
        .b_req(b_req), .b_op1(b_op1), .b_op2(b_op2), .b_ack(b_ack), .b_valid(b_valid),
        .res_out(res_out), .timeout(timeout), .busy(busy),
        .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_res(mul_res), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // requester agents
    bit          rst_next = 1'b1;
    bit          a_want = 0, b_want = 0, a_wd = 0, b_wd = 0, a_drop = 0, b_drop = 0;
    logic [31:0] a_n1, a_n2, b_n1, b_n2;
    int          a_lat_n, b_lat_n, a_lat, b_lat;

    // multiplier stub
    int          mcnt = 0;
    logic [31:0] mop1, mop2;
    bit          stray = 0;

    // reference model
    bit          inflight = 0, g_b = 0, g_to = 0, last_b = 1;
    int          t_grant, rdy_c, val_c, free_c = 1 << 30, g_lat;
    logic [31:0] g_op1, g_op2, g_res, held = '0;
    logic [7:0]  ord = '0;
    int          nack = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Known IEEE products for the named vectors; other operand pairs get a stub hash.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h40000000, 32'h40200000}: return 32'h40A00000;
            {32'h3FA00000, 32'h3F800000}: return 32'h3FA00000;
            {32'h42C86666, 32'h80000000}: return 32'h80000000;
            {32'hFF800000, 32'h45185B75}: return 32'hFF800000;
            default:                      return (x * 32'h9E3779B1) ^ {y[15:0], y[31:16]};
        endcase
    endfunction

    task automatic sample();
        bit ea, eb;
        ea = 0;
        eb = 0;
        if (rst) begin
            inflight = 0;
            held     = '0;
            last_b   = 1;
            free_c   = cyc + 1;
        end
        if (inflight && cyc > val_c) inflight = 0;
        if (!rst && !inflight && cyc >= free_c) begin
            ea = a_req && (!b_req || last_b);
            eb = b_req && !ea;
        end
        if (a_ack === 1'b1) begin ord = {ord[6:0], 1'b0}; nack++; end
        if (b_ack === 1'b1) begin ord = {ord[6:0], 1'b1}; nack++; end
        chk("a_ack", a_ack, ea);
        chk("b_ack", b_ack, eb);
        chk("busy", busy, inflight && cyc > t_grant);
        chk("mul_ready", mul_ready, inflight && cyc == rdy_c);
        chk("a_valid", a_valid, inflight && cyc == val_c && !g_b);
        chk("b_valid", b_valid, inflight && cyc == val_c && g_b);
        chk("timeout", timeout, inflight && cyc == val_c && g_to);
        if (inflight && cyc == val_c) held = g_res;
        chk("res_out", res_out, held);
        if (rst) begin
            chk("mul_op1_rst", mul_op1, 32'h0);
            chk("mul_op2_rst", mul_op2, 32'h0);
        end else if (inflight && cyc > t_grant) begin
            chk("mul_op1", mul_op1, g_op1);
            chk("mul_op2", mul_op2, g_op2);
        end
        if (mul_ready === 1'b1) begin
            mop1 = mul_op1;
            mop2 = mul_op2;
            mcnt = g_lat;
        end
        if (ea || eb) begin
            inflight = 1;
            g_b      = eb;
            g_op1    = eb ? b_op1 : a_op1;
            g_op2    = eb ? b_op2 : a_op2;
            g_lat    = eb ? b_lat : a_lat;
            t_grant  = cyc;
            rdy_c    = cyc + 1;
            if (g_lat != NEVER && g_lat <= TO) begin
                val_c = cyc + g_lat + 2;
                g_res = fmul(g_op1, g_op2);
                g_to  = 0;
            end else begin
                val_c = cyc + TO + 2;
                g_res = TOR;
                g_to  = 1;
            end
            free_c = val_c + 1;
            last_b = eb;
            if (eb) b_drop = 1; else a_drop = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_next;
        if (a_drop) begin a_req = 0; a_drop = 0; end
        if (b_drop) begin b_req = 0; b_drop = 0; end
        if (a_wd) begin a_req = 0; a_wd = 0; end
        if (b_wd) begin b_req = 0; b_wd = 0; end
        if (a_want) begin a_req = 1; a_op1 = a_n1; a_op2 = a_n2; a_lat = a_lat_n; a_want = 0; end
        if (b_want) begin b_req = 1; b_op1 = b_n1; b_op2 = b_n2; b_lat = b_lat_n; b_want = 0; end
        mul_done = 0;
        if (rst) mcnt = 0;
        else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin mul_done = 1; mul_res = fmul(mop1, mop2); end
        end
        if (stray) begin mul_done = 1; mul_res = $urandom; stray = 0; end
        #1;
        sample();
    endtask

    task automatic req_a(input logic [31:0] x, input logic [31:0] y, input int lat);
        a_want = 1; a_n1 = x; a_n2 = y; a_lat_n = lat;
    endtask

    task automatic req_b(input logic [31:0] x, input logic [31:0] y, input int lat);
        b_want = 1; b_n1 = x; b_n2 = y; b_lat_n = lat;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((inflight || a_req || b_req || a_want || b_want) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            failures++;
            $error("FAIL wait_idle observed=%0d cycles expected=below %0d", n, budget);
        end
        cycle();
    endtask

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 11);
        if (r < 7)       return 18;
        else if (r == 7) return $urandom_range(1, TO);
        else if (r == 8) return TO;
        else if (r == 9) return NEVER;
        else             return $urandom_range(TO + 1, TO + 3);
    endfunction

    initial begin
        int n;
        // reset held with a request pending: no ack until release
        req_a(32'h40000000, 32'h40200000, 18);
        repeat (4) cycle();
        chk("rst_a_ack", a_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_next = 0;
        wait_idle(200);

        req_b(32'hFF800000, 32'h45185B75, 18);
        wait_idle(200);

        // contention, then A re-requests while B is being served
        ord = '0;
        nack = 0;
        req_a(32'h3FA00000, 32'h3F800000, 18);
        req_b(32'h42C86666, 32'h80000000, 18);
        n = 0;
        while (!(inflight && g_b) && n < 200) begin cycle(); n++; end
        req_a(32'h3F800000, 32'h40400000, 18);
        wait_idle(300);
        chk("contention_order", ord, 8'b0000_0010);
        chk("contention_acks", nack, 3);

        // timeout boundaries
        req_a(32'h12345678, 32'h9ABCDEF0, NEVER);
        wait_idle(200);
        req_b(32'h3F800000, 32'h3F800000, TO);
        wait_idle(200);
        req_a(32'h40000000, 32'h40000000, TO + 1);
        wait_idle(200);

        // stray completion while idle must not disturb res_out
        stray = 1;
        repeat (3) cycle();

        // withdrawn request while busy is never acked
        req_b(32'h41000000, 32'h41100000, 18);
        repeat (3) cycle();
        req_a(32'h41200000, 32'h41300000, 18);
        repeat (2) cycle();
        a_wd = 1;
        wait_idle(200);

        // reset five cycles after mul_ready, then a normal operation
        req_a(32'h40400000, 32'h40800000, 18);
        n = 0;
        while (!(inflight && cyc == rdy_c + 4) && n < 200) begin cycle(); n++; end
        rst_next = 1;
        cycle();
        chk("midwait_rst_busy", busy, 1'b0);
        rst_next = 0;
        cycle();
        req_b(32'h40A00000, 32'h40C00000, 18);
        wait_idle(200);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!a_req && !a_want && $urandom_range(0, 7) == 0)
                req_a($urandom, $urandom, rand_lat());
            if (!b_req && !b_want && $urandom_range(0, 7) == 0)
                req_b($urandom, $urandom, rand_lat());
            if (a_req && !a_drop && $urandom_range(0, 63) == 0) a_wd = 1;
            if (b_req && !b_drop && $urandom_range(0, 63) == 0) b_wd = 1;
            if (!inflight && $urandom_range(0, 31) == 0) stray = 1;
            cycle();
        end
        wait_idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Shares one multi-cycle single-precision multiplier (`double_multipler`: ready/op1/op2 in, res/done out) between two requesters, A and B. Round-robin arbitration picks a requester, latches its operands, and issues them to the multiplier with a one-cycle ready pulse. It waits for done, or for a timeout, then returns the result to the granted requester with a one-cycle valid pulse. It sits between the multiplier and the two client datapaths, and only one operation is in flight at a time.

Parameters:
TIMEOUT_CYCLES, 32, max cycles spent in WAIT for mul_done before the operation is aborted; must be >= 20 (multiplier latency ~18).
TO_RESULT, 32'h7FC00000, result word returned on timeout (quiet NaN).

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
a_req  in  1  requester A operation request (level, held until a_ack)
a_op1  in  32  requester A operand 1 (IEEE754 single)
a_op2  in  32  requester A operand 2
a_ack  out  1  one-cycle pulse: A's operands captured
a_valid  out  1  one-cycle pulse: res_out is A's result
b_req  in  1  requester B request
b_op1  in  32  requester B operand 1
b_op2  in  32  requester B operand 2
b_ack  out  1  one-cycle pulse: B's operands captured
b_valid  out  1  one-cycle pulse: res_out is B's result
res_out  out  32  result word, held until the next result
timeout  out  1  one-cycle pulse, coincident with the a_valid/b_valid of an aborted operation
busy  out  1  high in every state except IDLE
mul_ready  out  1  one-cycle start pulse to the multiplier
mul_op1  out  32  operand 1 to the multiplier
mul_op2  out  32  operand 2 to the multiplier
mul_res  in  32  multiplier result
mul_done  in  1  multiplier completion pulse

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs are 0, including res_out, mul_op1 and mul_op2.
  - The last_grant register is set to B, so A wins the first contention.
  - The wait counter is 0.
- The multiplier is driven by the same clk/rst. A reset mid-operation aborts the operation with no valid or ack pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the one that is not last_grant.
  - On grant, latch the granted ops into mul_op1/mul_op2, pulse the granted x_ack, update last_grant, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: mul_ready=1 for exactly this cycle. Clear the counter and go to WAIT.
- WAIT:
  - mul_op1/mul_op2 are held stable for the entire operation, from ISSUE through RESP.
  - The counter increments every cycle.
  - If mul_done=1: latch mul_res into res_out and go to RESP.
  - Else, if counter reaches TIMEOUT_CYCLES-1: load res_out=TO_RESULT, set a timeout flag, and go to RESP.
  - If mul_done and the timeout condition occur in the same cycle, mul_done wins and no timeout is reported.
- RESP:
  - Pulse x_valid for the granted requester. Pulse timeout if the flag is set, then clear the flag.
  - Return to IDLE. A new grant can occur no earlier than the cycle after RESP.
- mul_done outside WAIT is ignored. A stray mul_done does not change res_out.
- Requests arriving while busy are not acked; a requester keeps req high until it receives x_ack.
- Deasserting req before ack withdraws the request, with no side effect.
- Latency, request to valid: ack at IDLE cycle T, mul_ready at T+1, valid at the cycle after mul_done. With an 18-cycle multiplier this is about T+20.
- Throughput: one operation per (multiplier latency + 3) cycles.
- Arbitration is strict alternation under continuous contention. A lone requester may be granted back-to-back.

Test Plan:
- Reset: rst pulse with requests held -> every output is 0, and there is no ack until rst falls.
- A alone, a_op1=32'h40000000 (2.0), a_op2=32'h40200000 (2.5) -> one a_ack, mul_ready one cycle later with the same ops, then a_valid with res_out=32'h40A00000 (5.0), and b_valid stays 0.
- Contention: A=(32'h3FA00000 (1.25), 32'h3F800000 (1.0)) and B=(32'h42C86666 (100.2), 32'h80000000 (-0.0)) raised in the same cycle -> A is served first with res 32'h3FA00000. B is then served with res 32'h80000000. A re-requesting during B's operation is served after B.
- Specials: B=(32'hFF800000 (-inf), 32'h45185B75 (2437.716)) -> b_valid with res_out=32'hFF800000.
- Timeout: replace the multiplier with a stub that never asserts done -> after TIMEOUT_CYCLES in WAIT, x_valid and timeout pulse together with res_out=32'h7FC00000, and the FSM returns to IDLE. A stub asserting done in the final WAIT cycle gives a normal result with no timeout.
- Reset mid-WAIT: assert rst 5 cycles after mul_ready -> busy=0 immediately, no valid pulse, and the next request proceeds normally.
